// File: rtl/steer_en_ctrl.sv
// steer_en_ctrl: rider-detect and steer-enable controller with a settle timer.
// Define STEER_EN_FAST_SIM_EN to shorten the settle to 2^15 cycles for simulation.
module steer_en_ctrl #(
    parameter int              LD_W          = 12,
    parameter logic [LD_W-1:0] MIN_RIDER_WT  = 12'h200,
    parameter logic [LD_W-1:0] WT_HYSTERESIS = 12'h040,
    parameter int              TMR_W         = 26
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld_vld,
    input  logic [LD_W-1:0] lft_ld,
    input  logic [LD_W-1:0] rght_ld,
    output logic            en_steer,
    output logic            rider_off,
    output logic [1:0]      steer_state
);
    typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, STEER = 2'b10} state_e;
    localparam int SW = LD_W + 1;
    localparam logic [LD_W:0] THR_HI = SW'(MIN_RIDER_WT) + SW'(WT_HYSTERESIS);
    localparam logic [LD_W:0] THR_LO = SW'(MIN_RIDER_WT) - SW'(WT_HYSTERESIS);
    logic [LD_W-1:0]  lft_q, rght_q, abs_diff;
    logic [LD_W:0]    sum, diff_s, neg_diff;
    logic [TMR_W-1:0] tmr_q;
    logic [1:0]       state_q;
    logic             sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16, tmr_full;
    assign sum           = {1'b0, lft_q} + {1'b0, rght_q};
    assign diff_s        = {1'b0, lft_q} - {1'b0, rght_q};
    assign neg_diff      = -diff_s;
    assign abs_diff      = diff_s[LD_W] ? neg_diff[LD_W-1:0] : diff_s[LD_W-1:0];
    assign sum_gt_min    = sum > THR_HI;
    assign sum_lt_min    = sum < THR_LO;
    assign diff_gt_1_4   = {1'b0, abs_diff} > (sum >> 2);
    assign diff_gt_15_16 = {1'b0, abs_diff} > (sum - (sum >> 4));
`ifdef STEER_EN_FAST_SIM_EN
    assign tmr_full = &tmr_q[14:0];
`else
    assign tmr_full = &tmr_q;
`endif
    // Outputs decode straight from the state register; the illegal code reads as IDLE.
    assign steer_state = state_q;
    assign en_steer    = state_q == STEER;
    assign rider_off   = state_q != WAIT && state_q != STEER;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lft_q   <= '0;
            rght_q  <= '0;
            tmr_q   <= '0;
        end else begin
            if (ld_vld) begin
                lft_q  <= lft_ld;
                rght_q <= rght_ld;
            end
            case (state_q)
                IDLE: if (sum_gt_min) begin
                    state_q <= WAIT;
                    tmr_q   <= '0;
                end
                WAIT: if (sum_lt_min) state_q <= IDLE;
                    else if (diff_gt_1_4) tmr_q <= '0;
                    else if (tmr_full) state_q <= STEER;
                    else tmr_q <= tmr_q + TMR_W'(1);
                STEER: if (sum_lt_min) state_q <= IDLE;
                    else if (diff_gt_15_16) begin
                        state_q <= WAIT;
                        tmr_q   <= '0;
                    end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
